// File: rtl/systolic_result_drain.sv
// Result drain for the systolic array: snapshots the NxN int32 accumulator grid,
// requantizes it to int8 and streams one row per valid/ready handshake.
module systolic_result_drain #(
    parameter int N     = 4,
    parameter int ROW_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [N-1:0][N-1:0][31:0] c_in,
    input  logic [15:0]               q_mult,
    input  logic [4:0]                q_shift,
    input  logic [7:0]                q_zp,
    output logic [N-1:0][7:0]         out_data,
    output logic [ROW_W-1:0]          out_row,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      clear_acc,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        CLEAR
    } state_t;

    state_t                    state_q;
    logic [N-1:0][N-1:0][31:0] snap_q;
    logic [15:0]               mult_q;
    logic [4:0]                shift_q;
    logic [7:0]                zp_q;
    logic [N-1:0][7:0]         data_q;
    logic [ROW_W-1:0]          row_q;
    logic                      valid_q;
    logic                      last_q;
    logic                      clear_q;
    logic                      busy_q;
    logic                      done_q;

    logic [ROW_W-1:0]          row_d;
    logic [N-1:0][7:0]         data_d;
    logic                      last_d;
    logic                      final_row;

    // 48 bits covers int32 * int16 plus rounding and zero point without overflow.
    function automatic logic [7:0] requant(
        input logic [31:0] acc,
        input logic [15:0] mult,
        input logic [4:0]  sh,
        input logic [7:0]  zp
    );
        logic signed [47:0] p;
        logic signed [47:0] rnd;
        logic signed [47:0] s;
        logic signed [47:0] t;
        p   = 48'($signed(acc)) * 48'($signed(mult));
        rnd = (sh == 5'd0) ? 48'sd0 : (48'sd1 <<< (sh - 5'd1));
        s   = (p + rnd) >>> sh;
        t   = s + 48'($signed(zp));
        if (t > 48'sd127) begin
            return 8'h7f;
        end else if (t < -48'sd128) begin
            return 8'h80;
        end else begin
            return t[7:0];
        end
    endfunction

    always_comb begin
        row_d = (state_q == LOAD) ? '0 : row_q + ROW_W'(1);
        for (int j = 0; j < N; j++) begin
            data_d[j] = requant(snap_q[row_d][j], mult_q, shift_q, zp_q);
        end
        last_d    = (row_d == ROW_W'(N - 1));
        final_row = (row_q == ROW_W'(N - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            snap_q  <= '0;
            mult_q  <= '0;
            shift_q <= '0;
            zp_q    <= '0;
            data_q  <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            clear_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        snap_q  <= c_in;
                        mult_q  <= q_mult;
                        shift_q <= q_shift;
                        zp_q    <= q_zp;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    data_q  <= data_d;
                    row_q   <= row_d;
                    last_q  <= last_d;
                    valid_q <= 1'b1;
                    state_q <= DRAIN;
                end
                DRAIN: begin
                    if (valid_q && out_ready) begin
                        if (final_row) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            clear_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= CLEAR;
                        end else begin
                            data_q <= data_d;
                            row_q  <= row_d;
                            last_q <= last_d;
                        end
                    end
                end
                CLEAR: begin
                    clear_q <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_data  = data_q;
    assign out_row   = row_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign clear_acc = clear_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain (N=2): identity, requant rounding and
// saturation, backpressure, snapshot isolation, ignored start, mid-drain reset.
module tb_systolic_result_drain;

    localparam int N = 2;

    logic                      clk;
    logic                      reset;
    logic                      start;
    logic [N-1:0][N-1:0][31:0] c_in;
    logic [15:0]               q_mult;
    logic [4:0]                q_shift;
    logic [7:0]                q_zp;
    logic [N-1:0][7:0]         out_data;
    logic [0:0]                out_row;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_last;
    logic                      clear_acc;
    logic                      busy;
    logic                      done;

    int n_chk;
    int n_pass;

    systolic_result_drain #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .c_in      (c_in),
        .q_mult    (q_mult),
        .q_shift   (q_shift),
        .q_zp      (q_zp),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .clear_acc (clear_acc),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0][N-1:0][31:0] mkg(
        input int a00, input int a01, input int a10, input int a11
    );
        logic [N-1:0][N-1:0][31:0] g;
        g[0][0] = 32'(a00);
        g[0][1] = 32'(a01);
        g[1][0] = 32'(a10);
        g[1][1] = 32'(a11);
        return g;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_data"}, 32'(out_data), 32'h0);
        chk({tag, "_row"}, 32'(out_row), 32'h0);
        chk({tag, "_valid"}, 32'(out_valid), 32'h0);
        chk({tag, "_last"}, 32'(out_last), 32'h0);
        chk({tag, "_clr"}, 32'(clear_acc), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
    endtask

    task automatic run_tile(input string tag,
                            input logic [N-1:0][N-1:0][31:0] g,
                            input logic [15:0] m, input logic [4:0] sh,
                            input logic [7:0] zp,
                            input logic [15:0] e0, input logic [15:0] e1,
                            input bit scramble);
        c_in      = g;
        q_mult    = m;
        q_shift   = sh;
        q_zp      = zp;
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        if (scramble) begin
            c_in    = ~g;
            q_mult  = 16'h7fff;
            q_shift = 5'd0;
            q_zp    = 8'h55;
        end
        chk({tag, "_busy0"}, 32'(busy), 32'h1);
        chk({tag, "_v0"}, 32'(out_valid), 32'h0);
        step();
        chk({tag, "_d0"}, 32'(out_data), 32'(e0));
        chk({tag, "_r0"}, 32'(out_row), 32'h0);
        chk({tag, "_v1"}, 32'(out_valid), 32'h1);
        chk({tag, "_l0"}, 32'(out_last), 32'h0);
        step();
        chk({tag, "_d1"}, 32'(out_data), 32'(e1));
        chk({tag, "_r1"}, 32'(out_row), 32'h1);
        chk({tag, "_l1"}, 32'(out_last), 32'h1);
        chk({tag, "_v2"}, 32'(out_valid), 32'h1);
        step();
        chk({tag, "_clr"}, 32'(clear_acc), 32'h1);
        chk({tag, "_done"}, 32'(done), 32'h1);
        chk({tag, "_v3"}, 32'(out_valid), 32'h0);
        chk({tag, "_l2"}, 32'(out_last), 32'h0);
        chk({tag, "_busyc"}, 32'(busy), 32'h1);
        step();
        chk({tag, "_clr0"}, 32'(clear_acc), 32'h0);
        chk({tag, "_done0"}, 32'(done), 32'h0);
        chk({tag, "_busy1"}, 32'(busy), 32'h0);
    endtask

    initial begin
        logic [N-1:0][N-1:0][31:0] gid;
        n_chk     = 0;
        n_pass    = 0;
        reset     = 1'b1;
        start     = 1'b0;
        c_in      = '0;
        q_mult    = '0;
        q_shift   = '0;
        q_zp      = '0;
        out_ready = 1'b0;
        gid       = mkg(19, 22, 43, 50);
        step();
        step();
        chk_idle("rst");
        reset = 1'b0;
        step();
        chk_idle("rst_rel");

        run_tile("ident", gid, 16'd1, 5'd0, 8'd0, 16'h1613, 16'h322b, 1'b0);
        // ties round toward +inf: 2 -> 1, -2 -> 0
        run_tile("rndA", mkg(-90, -100, 2, -2), 16'd1, 5'd2, 8'd0,
                 16'he7ea, 16'h0001, 1'b0);
        run_tile("satB", mkg(1000, -1000, 8, 0), 16'd3, 5'd4, 8'd0,
                 16'h807f, 16'h0002, 1'b0);
        run_tile("zpC", mkg(10, -5000, 122, 123), 16'd1, 5'd0, 8'd5,
                 16'h800f, 16'h7f7f, 1'b0);
        run_tile("iso", gid, 16'd2, 5'd1, 8'hfd, 16'h1310, 16'h2f28, 1'b1);

        // backpressure on row 0
        c_in      = gid;
        q_mult    = 16'd1;
        q_shift   = 5'd0;
        q_zp      = 8'd0;
        out_ready = 1'b0;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("bp_v", 32'(out_valid), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("bp_hold_d%0d", i), 32'(out_data), 32'h1613);
            chk($sformatf("bp_hold_r%0d", i), 32'(out_row), 32'h0);
            chk($sformatf("bp_hold_v%0d", i), 32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        step();
        chk("bp_d1", 32'(out_data), 32'h322b);
        chk("bp_r1", 32'(out_row), 32'h1);
        step();
        chk("bp_done", 32'(done), 32'h1);
        step();
        chk("bp_idle", 32'(busy), 32'h0);

        // start during DRAIN and during CLEAR is ignored
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        out_ready = 1'b0;
        start     = 1'b1;
        c_in      = mkg(1, 2, 3, 4);
        step();
        start = 1'b0;
        chk("ign_r0", 32'(out_row), 32'h0);
        chk("ign_d0", 32'(out_data), 32'h1613);
        out_ready = 1'b1;
        step();
        chk("ign_d1", 32'(out_data), 32'h322b);
        step();
        chk("ign_done", 32'(done), 32'h1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ign_busy", 32'(busy), 32'h0);
        chk("ign_done0", 32'(done), 32'h0);
        step();
        chk("ign_busy2", 32'(busy), 32'h0);
        chk("ign_v", 32'(out_valid), 32'h0);

        // reset after the row 0 transfer abandons the tile
        c_in      = gid;
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("mr_r1", 32'(out_row), 32'h1);
        reset = 1'b1;
        #1;
        chk_idle("mr_rst");
        step();
        reset = 1'b0;
        step();
        chk_idle("mr_after");
        run_tile("mr_fresh", mkg(-90, -100, 2, -2), 16'd1, 5'd2, 8'd0,
                 16'he7ea, 16'h0001, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
